// File: rtl/mem_arbiter.sv
// Arbiter that gives the byte-serial memory controller to the instruction fetcher or the load/store buffer, one whole transaction at a time.
// Optional build macro STARVE_GUARD_EN adds a counter that forces a fetch grant after STARVE_MAX back-to-back LSB grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iIO_buffer_full,
  input  logic              iCLR,
  input  logic              iINF_req,
  input  logic [ADDR_W-1:0] iINF_addr,
  output logic              oINF_done,
  output logic [31:0]       oINF_inst,
  input  logic              iLS_req,
  input  logic              iLS_st,
  input  logic [2:0]        iLS_len,
  input  logic [ADDR_W-1:0] iLS_addr,
  input  logic [31:0]       iLS_dt,
  output logic              oLS_done,
  output logic [31:0]       oLS_dt,
  output logic              oMC_en,
  output logic              oMC_st,
  output logic [2:0]        oMC_len,
  output logic [ADDR_W-1:0] oMC_addr,
  output logic [31:0]       oMC_dt,
  input  logic              iMC_done,
  input  logic [31:0]       iMC_dt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_INF = 2'd1,
    BUSY_LS  = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        grant_ls, grant_inf;
  logic        inf_done_n, ls_done_n, mc_en_n;
  logic        can_grant, force_inf;
  logic [31:0] load_data;

  assign dbg_state = state;

  // No grant while a done pulse is out: the finishing requester still holds its req that cycle.
  assign can_grant = !iIO_buffer_full && !iCLR && !oINF_done && !oLS_done;

`ifdef STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign force_inf = (starve_cnt == CW'(STARVE_MAX)) && iINF_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (rdy) begin
      if (grant_inf) begin
        starve_cnt <= '0;
      end else if (grant_ls) begin
        if (!iINF_req)
          starve_cnt <= '0;
        else if (starve_cnt != CW'(STARVE_MAX))
          starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end
`else
  // Guard disabled: the comparison is constant false, strict LSB priority remains.
  assign force_inf = (STARVE_MAX < 0);
`endif

  always_comb begin
    state_n    = state;
    grant_ls   = 1'b0;
    grant_inf  = 1'b0;
    inf_done_n = 1'b0;
    ls_done_n  = 1'b0;
    mc_en_n    = oMC_en;
    case (state)
      IDLE: begin
        if (can_grant) begin
          if (iLS_req && !force_inf) begin
            grant_ls = 1'b1;
            state_n  = BUSY_LS;
            mc_en_n  = 1'b1;
          end else if (iINF_req) begin
            grant_inf = 1'b1;
            state_n   = BUSY_INF;
            mc_en_n   = 1'b1;
          end
        end
      end
      BUSY_INF: begin
        if (iMC_done) begin
          state_n    = IDLE;
          mc_en_n    = 1'b0;
          inf_done_n = !iCLR;
        end else if (iCLR) begin
          state_n = DRAIN;
        end
      end
      BUSY_LS: begin
        // A store always reports completion; a load is dropped by a clear.
        if (iMC_done) begin
          state_n   = IDLE;
          mc_en_n   = 1'b0;
          ls_done_n = oMC_st || !iCLR;
        end else if (iCLR && !oMC_st) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (iMC_done) begin
          state_n = IDLE;
          mc_en_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    load_data = iMC_dt;
    case (oMC_len)
      3'd1:    load_data = {24'b0, iMC_dt[7:0]};
      3'd2:    load_data = {16'b0, iMC_dt[15:0]};
      default: load_data = iMC_dt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (rdy)
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oMC_en    <= 1'b0;
      oMC_st    <= 1'b0;
      oMC_len   <= 3'd0;
      oMC_addr  <= '0;
      oMC_dt    <= 32'd0;
      oINF_done <= 1'b0;
      oINF_inst <= 32'd0;
      oLS_done  <= 1'b0;
      oLS_dt    <= 32'd0;
    end else if (rdy) begin
      oMC_en    <= mc_en_n;
      oINF_done <= inf_done_n;
      oLS_done  <= ls_done_n;
      if (grant_ls) begin
        oMC_st   <= iLS_st;
        oMC_len  <= iLS_len;
        oMC_addr <= iLS_addr;
        oMC_dt   <= iLS_dt;
      end else if (grant_inf) begin
        oMC_st   <= 1'b0;
        oMC_len  <= 3'd4;
        oMC_addr <= iINF_addr;
        oMC_dt   <= 32'd0;
      end
      if (inf_done_n)
        oINF_inst <= iMC_dt;
      if (ls_done_n)
        oLS_dt <= oMC_st ? 32'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the memory controller is played by hand-timed iMC_done pulses.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam logic [1:0] S_IDLE = 2'd0, S_BINF = 2'd1, S_BLS = 2'd2, S_DRAIN = 2'd3;

  logic              clk = 1'b0;
  logic              rst, rdy, iIO_buffer_full, iCLR;
  logic              iINF_req;
  logic [ADDR_W-1:0] iINF_addr;
  logic              oINF_done;
  logic [31:0]       oINF_inst;
  logic              iLS_req, iLS_st;
  logic [2:0]        iLS_len;
  logic [ADDR_W-1:0] iLS_addr;
  logic [31:0]       iLS_dt;
  logic              oLS_done;
  logic [31:0]       oLS_dt;
  logic              oMC_en, oMC_st;
  logic [2:0]        oMC_len;
  logic [ADDR_W-1:0] oMC_addr;
  logic [31:0]       oMC_dt;
  logic              iMC_done;
  logic [31:0]       iMC_dt;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iIO_buffer_full(iIO_buffer_full), .iCLR(iCLR),
    .iINF_req(iINF_req), .iINF_addr(iINF_addr), .oINF_done(oINF_done), .oINF_inst(oINF_inst),
    .iLS_req(iLS_req), .iLS_st(iLS_st), .iLS_len(iLS_len), .iLS_addr(iLS_addr), .iLS_dt(iLS_dt),
    .oLS_done(oLS_done), .oLS_dt(oLS_dt),
    .oMC_en(oMC_en), .oMC_st(oMC_st), .oMC_len(oMC_len), .oMC_addr(oMC_addr), .oMC_dt(oMC_dt),
    .iMC_done(iMC_done), .iMC_dt(iMC_dt), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mc_complete(input logic [31:0] d);
    iMC_done = 1'b1;
    iMC_dt   = d;
    step();
    iMC_done = 1'b0;
    iMC_dt   = 32'd0;
  endtask

  task automatic wait_en();
    int k;
    k = 0;
    while (!oMC_en && k < 8) begin
      step();
      k++;
    end
    check("grant_timeout", oMC_en, 1);
  endtask

  task automatic ls_req(input logic st, input logic [2:0] len, input logic [31:0] addr, input logic [31:0] dt);
    iLS_req  = 1'b1;
    iLS_st   = st;
    iLS_len  = len;
    iLS_addr = addr;
    iLS_dt   = dt;
  endtask

  logic [2:0]  ld_len[3];
  logic [31:0] ld_raw[3];
  logic [31:0] ld_exp[3];

  initial begin
    rst = 1'b1; rdy = 1'b1; iIO_buffer_full = 1'b0; iCLR = 1'b0;
    iINF_req = 1'b0; iINF_addr = '0;
    iLS_req = 1'b0; iLS_st = 1'b0; iLS_len = 3'd0; iLS_addr = '0; iLS_dt = 32'd0;
    iMC_done = 1'b0; iMC_dt = 32'd0;
    step();
    step();
    rst = 1'b0;
    check("rst_en", oMC_en, 0);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_inf_done", oINF_done, 0);
    check("rst_ls_done", oLS_done, 0);
    check("rst_ls_dt", oLS_dt, 0);

    // Lone fetch
    iINF_req = 1'b1; iINF_addr = 32'h1000;
    step();
    check("fetch_en", oMC_en, 1);
    check("fetch_len", oMC_len, 4);
    check("fetch_addr", oMC_addr, 32'h1000);
    check("fetch_st", oMC_st, 0);
    step();
    check("fetch_hold_en", oMC_en, 1);
    mc_complete(32'h00A00093);
    check("fetch_done", oINF_done, 1);
    check("fetch_inst", oINF_inst, 32'h00A00093);
    check("fetch_en_off", oMC_en, 0);
    step();
    check("fetch_done_pulse", oINF_done, 0);
    check("fetch_no_regrant", oMC_en, 0);
    iINF_req = 1'b0;
    step();

    // Contention: store wins, fetch follows after one idle bubble
    iINF_req = 1'b1; iINF_addr = 32'h3000;
    ls_req(1'b1, 3'd2, 32'h2000, 32'h0000BEEF);
    step();
    check("cont_st", oMC_st, 1);
    check("cont_addr", oMC_addr, 32'h2000);
    check("cont_len", oMC_len, 2);
    check("cont_dt", oMC_dt, 32'h0000BEEF);
    mc_complete(32'h0);
    check("cont_ls_done", oLS_done, 1);
    check("cont_inf_idle", oINF_done, 0);
    iLS_req = 1'b0;
    step();
    check("cont_bubble", oMC_en, 0);
    step();
    check("cont_fetch_en", oMC_en, 1);
    check("cont_fetch_addr", oMC_addr, 32'h3000);
    check("cont_fetch_st", oMC_st, 0);
    mc_complete(32'h12345678);
    check("cont_fetch_done", oINF_done, 1);
    check("cont_fetch_inst", oINF_inst, 32'h12345678);
    iINF_req = 1'b0;
    step();

    // Load zero-extension per length
    ld_len[0] = 3'd1; ld_raw[0] = 32'hFFFFFF80; ld_exp[0] = 32'h00000080;
    ld_len[1] = 3'd2; ld_raw[1] = 32'hFFFF8001; ld_exp[1] = 32'h00008001;
    ld_len[2] = 3'd4; ld_raw[2] = 32'hCAFEBABE; ld_exp[2] = 32'hCAFEBABE;
    for (int i = 0; i < 3; i++) begin
      ls_req(1'b0, ld_len[i], 32'h44 + i, 32'h0);
      step();
      check("load_len", oMC_len, ld_len[i]);
      check("load_st", oMC_st, 0);
      mc_complete(ld_raw[i]);
      check("load_done", oLS_done, 1);
      check("load_dt", oLS_dt, ld_exp[i]);
      iLS_req = 1'b0;
      step();
    end

    // Clear during fetch drains silently
    iINF_req = 1'b1; iINF_addr = 32'h1004;
    step();
    iCLR = 1'b1; iINF_req = 1'b0;
    step();
    iCLR = 1'b0;
    check("drain_state", dbg_state, S_DRAIN);
    check("drain_en", oMC_en, 1);
    step();
    check("drain_hold_en", oMC_en, 1);
    mc_complete(32'hDEADBEEF);
    check("drain_no_done", oINF_done, 0);
    check("drain_en_off", oMC_en, 0);
    check("drain_idle", dbg_state, S_IDLE);
    step();

    // Clear during store is ignored
    ls_req(1'b1, 3'd4, 32'h50, 32'h11223344);
    step();
    iCLR = 1'b1;
    step();
    iCLR = 1'b0;
    check("clr_st_state", dbg_state, S_BLS);
    check("clr_st_en", oMC_en, 1);
    mc_complete(32'h0);
    check("clr_st_done", oLS_done, 1);
    iLS_req = 1'b0;
    step();

    // Clear coinciding with load completion: no done pulse
    ls_req(1'b0, 3'd4, 32'h58, 32'h0);
    step();
    iCLR = 1'b1; iLS_req = 1'b0;
    mc_complete(32'h55AA55AA);
    iCLR = 1'b0;
    check("clr_ld_no_done", oLS_done, 0);
    check("clr_ld_en_off", oMC_en, 0);
    check("clr_ld_idle", dbg_state, S_IDLE);
    step();

    // Clear in IDLE blocks the grant that cycle
    iINF_req = 1'b1; iINF_addr = 32'h1008; iCLR = 1'b1;
    step();
    iCLR = 1'b0;
    check("clr_idle_block", oMC_en, 0);
    step();
    check("clr_idle_then_grant", oMC_en, 1);
    mc_complete(32'h1);
    // rdy low freezes the done pulse
    rdy = 1'b0;
    step();
    check("rdy_freeze_done", oINF_done, 1);
    check("rdy_freeze_en", oMC_en, 0);
    rdy = 1'b1; iINF_req = 1'b0;
    step();
    check("rdy_release_done", oINF_done, 0);
    step();

    // IO stall
    iIO_buffer_full = 1'b1;
    ls_req(1'b0, 3'd4, 32'h60, 32'h0);
    step();
    check("io_block0", oMC_en, 0);
    step();
    check("io_block1", oMC_en, 0);
    iIO_buffer_full = 1'b0;
    step();
    check("io_grant", oMC_en, 1);
    iIO_buffer_full = 1'b1;
    step();
    check("io_busy_hold", oMC_en, 1);
    iIO_buffer_full = 1'b0;
    mc_complete(32'h7);
    check("io_done", oLS_done, 1);
    iLS_req = 1'b0;
    step();

    // Continuous contention: grant order
`ifdef STARVE_GUARD_EN
    exp_q = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000, 32'h2000};
`else
    exp_q = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2000};
`endif
    iINF_req = 1'b1; iINF_addr = 32'h1000;
    ls_req(1'b0, 3'd4, 32'h2000, 32'h0);
    for (int g = 0; g < 6; g++) begin
      wait_en();
      check("arb_order", oMC_addr, exp_q.pop_front());
      mc_complete(32'h0);
    end
    iINF_req = 1'b0; iLS_req = 1'b0;
    step();
    step();

    // Reset mid-transaction
    iINF_req = 1'b1; iINF_addr = 32'h100C;
    step();
    check("mid_rst_busy", dbg_state, S_BINF);
    rst = 1'b1; iINF_req = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_en", oMC_en, 0);
    check("mid_rst_done", oINF_done, 0);
    check("mid_rst_state", dbg_state, S_IDLE);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
